// File: rtl/pkg_bebidas.sv
// Shared types for the drink selector: drink codes, recipe layout, recipe ROM
// and selector state encoding.
package pkg_bebidas;

    typedef enum logic [2:0] {
        NINGUNA        = 3'd0,
        CAFE_NEGRO     = 3'd1,
        CAFE_CON_LECHE = 3'd2,
        CAPUCHINO      = 3'd3,
        MOCACCINO      = 3'd4,
        CHOCOLATE      = 3'd5
    } bebida_e;

    typedef struct packed {
        logic [1:0] agua;
        logic [1:0] cafe;
        logic [1:0] leche;
        logic [1:0] chocolate;
        logic [1:0] azucar;
    } receta_t;

    // Recipe times in seconds, indexed by drink code; codes 0, 6 and 7 map to all-zero.
    localparam receta_t RECETA_ROM [0:7] = '{
        '{agua: 2'd0, cafe: 2'd0, leche: 2'd0, chocolate: 2'd0, azucar: 2'd0},
        '{agua: 2'd3, cafe: 2'd2, leche: 2'd0, chocolate: 2'd0, azucar: 2'd1},
        '{agua: 2'd2, cafe: 2'd2, leche: 2'd2, chocolate: 2'd0, azucar: 2'd1},
        '{agua: 2'd1, cafe: 2'd2, leche: 2'd3, chocolate: 2'd0, azucar: 2'd1},
        '{agua: 2'd1, cafe: 2'd1, leche: 2'd2, chocolate: 2'd2, azucar: 2'd1},
        '{agua: 2'd2, cafe: 2'd0, leche: 2'd1, chocolate: 2'd3, azucar: 2'd1},
        '{agua: 2'd0, cafe: 2'd0, leche: 2'd0, chocolate: 2'd0, azucar: 2'd0},
        '{agua: 2'd0, cafe: 2'd0, leche: 2'd0, chocolate: 2'd0, azucar: 2'd0}
    };

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        BREWING = 2'd2
    } sel_state_e;

    function automatic logic es_bebida(input logic [2:0] code);
        return (code >= 3'd1) && (code <= 3'd5);
    endfunction

endpackage

// File: rtl/contador_segundos.sv
// Prescaler plus saturating 2-bit seconds counter with synchronous clear.
module contador_segundos #(
    parameter int TICKS_PER_SEC = 50_000_000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_clr,
    output logic [1:0] o_segundos
);
    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);

    logic [PW-1:0] r_presc;
    logic [1:0]    r_seg;
    logic          w_tick;

    assign w_tick = (r_presc == PRESC_MAX);

    // Clear wins over a coincident tick; seconds stop at 3.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_presc <= '0;
            r_seg   <= 2'd0;
        end else if (i_clr) begin
            r_presc <= '0;
            r_seg   <= 2'd0;
        end else if (w_tick) begin
            r_presc <= '0;
            if (r_seg != 2'd3)
                r_seg <= r_seg + 2'd1;
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    assign o_segundos = r_seg;

endmodule

// File: rtl/selector_receta.sv
// Captures the drink button, latches the recipe and holds the order until
// the brewing FSM reports completion.
//   state   | meaning
//   IDLE    | waiting for a 0 -> 1..5 button change
//   ARMED   | sel presented, waiting for the FSM to leave idle
//   BREWING | sel cleared, recipe held until finish with rst_segundos
module selector_receta
    import pkg_bebidas::*;
#(
    parameter int TICKS_PER_SEC = 50_000_000,
    parameter int SYNC_STAGES   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] btn,
    input  logic       sin_azucar,
    input  logic       rst_segundos,
    input  logic       finish,
    output logic [2:0] sel,
    output logic [1:0] segundos,
    output logic [1:0] t_agua,
    output logic [1:0] t_cafe,
    output logic [1:0] t_leche,
    output logic [1:0] t_chocolate,
    output logic [1:0] t_azucar,
    output logic       busy
);
    logic [2:0] r_sync [SYNC_STAGES];
    logic [2:0] r_btn_prev;
    logic [2:0] w_btn_s;
    logic       w_req;

    sel_state_e r_state, w_state_nxt;
    logic [2:0] r_sel, w_sel_nxt;
    receta_t    r_receta, w_receta_nxt;

    // Button synchronizer chain and previous-value register for change detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < SYNC_STAGES; i++)
                r_sync[i] <= 3'd0;
            r_btn_prev <= 3'd0;
        end else begin
            r_sync[0] <= btn;
            for (int i = 1; i < SYNC_STAGES; i++)
                r_sync[i] <= r_sync[i-1];
            r_btn_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_btn_s = r_sync[SYNC_STAGES-1];
    assign w_req   = (r_btn_prev == 3'd0) && es_bebida(w_btn_s);

    // State, sel and recipe registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_sel    <= 3'd0;
            r_receta <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_sel    <= w_sel_nxt;
            r_receta <= w_receta_nxt;
        end
    end

    // Next-state, next sel and next recipe.
    always_comb begin
        w_state_nxt  = r_state;
        w_sel_nxt    = r_sel;
        w_receta_nxt = r_receta;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    w_receta_nxt = RECETA_ROM[w_btn_s];
                    if (sin_azucar)
                        w_receta_nxt.azucar = 2'd0;
                    w_sel_nxt   = w_btn_s;
                    w_state_nxt = ARMED;
                end
            end
            ARMED: begin
                // Drop sel as the FSM leaves idle so it cannot re-trigger at the end.
                if (rst_segundos) begin
                    w_sel_nxt   = 3'd0;
                    w_state_nxt = BREWING;
                end
            end
            BREWING: begin
                w_sel_nxt = 3'd0;
                if (finish && rst_segundos) begin
                    w_receta_nxt = '0;
                    w_state_nxt  = IDLE;
                end
            end
            default: begin
                w_sel_nxt    = 3'd0;
                w_receta_nxt = '0;
                w_state_nxt  = IDLE;
            end
        endcase
    end

    contador_segundos #(
        .TICKS_PER_SEC(TICKS_PER_SEC)
    ) u_contador (
        .i_clk      (clk),
        .i_rst_n    (rst),
        .i_clr      (rst_segundos),
        .o_segundos (segundos)
    );

    assign sel         = r_sel;
    assign busy        = (r_state != IDLE);
    assign t_agua      = r_receta.agua;
    assign t_cafe      = r_receta.cafe;
    assign t_leche     = r_receta.leche;
    assign t_chocolate = r_receta.chocolate;
    assign t_azucar    = r_receta.azucar;

endmodule

// File: tb/tb_selector_receta.sv
// Scoreboard bench for selector_receta: the driver pushes expected orders,
// a negedge monitor pops them when sel is first presented and tracks seconds.
module tb_selector_receta;
    localparam int TPS  = 4;
    localparam int SYNC = 2;

    logic       clk;
    logic       rst;
    logic [2:0] btn;
    logic       sin_azucar;
    logic       rst_segundos;
    logic       finish;
    logic [2:0] sel;
    logic [1:0] segundos;
    logic [1:0] t_agua, t_cafe, t_leche, t_chocolate, t_azucar;
    logic       busy;

    selector_receta #(
        .TICKS_PER_SEC(TPS),
        .SYNC_STAGES  (SYNC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn          (btn),
        .sin_azucar   (sin_azucar),
        .rst_segundos (rst_segundos),
        .finish       (finish),
        .sel          (sel),
        .segundos     (segundos),
        .t_agua       (t_agua),
        .t_cafe       (t_cafe),
        .t_leche      (t_leche),
        .t_chocolate  (t_chocolate),
        .t_azucar     (t_azucar),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int code;
        int t [5];
    } orden_t;

    // agua, cafe, leche, chocolate, azucar per drink code
    int receta_ref [6][5] = '{
        '{0, 0, 0, 0, 0},
        '{3, 2, 0, 0, 1},
        '{2, 2, 2, 0, 1},
        '{1, 2, 3, 0, 1},
        '{1, 1, 2, 2, 1},
        '{2, 0, 1, 3, 1}
    };

    orden_t sb [$];
    int     n_chk  = 0;
    int     n_fail = 0;
    int     cur_t [5] = '{0, 0, 0, 0, 0};
    bit     exp_busy  = 0;
    int     m_cyc     = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Elapsed cycles since the last seconds clear.
    always @(posedge clk or negedge rst) begin
        if (!rst)              m_cyc <= 0;
        else if (rst_segundos) m_cyc <= 0;
        else                   m_cyc <= m_cyc + 1;
    end

    // Monitor: seconds every cycle, and scoreboard pop on each new sel presentation.
    logic [2:0] mon_prev_sel = 3'd0;
    always @(negedge clk) begin
        if (rst) begin
            int es;
            es = m_cyc / TPS;
            if (es > 3) es = 3;
            chk("segundos", int'(segundos), es);
            if (sel != 3'd0 && mon_prev_sel == 3'd0) begin
                if (sb.size() == 0) begin
                    chk("unexpected_sel", int'(sel), 0);
                end else begin
                    orden_t o;
                    int act [5];
                    o = sb.pop_front();
                    act = '{int'(t_agua), int'(t_cafe), int'(t_leche), int'(t_chocolate), int'(t_azucar)};
                    chk("sb_sel", int'(sel), o.code);
                    for (int i = 0; i < 5; i++)
                        chk($sformatf("sb_t%0d_code%0d", i, o.code), act[i], o.t[i]);
                end
            end
        end
        mon_prev_sel = sel;
    end

    task automatic chk_times(input string name);
        chk({name, "_agua"},  int'(t_agua),      cur_t[0]);
        chk({name, "_cafe"},  int'(t_cafe),      cur_t[1]);
        chk({name, "_leche"}, int'(t_leche),     cur_t[2]);
        chk({name, "_choc"},  int'(t_chocolate), cur_t[3]);
        chk({name, "_azuc"},  int'(t_azucar),    cur_t[4]);
    endtask

    // Press a button: go through 0 first, then the code; expect acceptance only when idle and valid.
    task automatic place_order(input int code, input bit sa);
        bit accept;
        btn = 3'd0;
        tick(SYNC + 1);
        sin_azucar = sa;
        btn = 3'(code);
        accept = !exp_busy && code >= 1 && code <= 5;
        if (accept) begin
            orden_t o;
            o.code = code;
            for (int i = 0; i < 5; i++) o.t[i] = receta_ref[code][i];
            if (sa) o.t[4] = 0;
            sb.push_back(o);
            cur_t = o.t;
        end
        tick(SYNC + 1);
        if (accept) exp_busy = 1;
        chk("busy_after_req", int'(busy), int'(exp_busy));
        chk("sel_after_req", int'(sel), accept ? code : 0);
        chk_times("t_after_req");
    endtask

    task automatic release_fsm();
        rst_segundos = 1'b1;
        tick(1);
        rst_segundos = 1'b0;
        chk("sel_cleared", int'(sel), 0);
        chk("busy_brewing", int'(busy), 1);
    endtask

    task automatic finish_alone();
        finish = 1'b1;
        tick(1);
        finish = 1'b0;
        chk("busy_finish_alone", int'(busy), 1);
        chk_times("t_hold");
    endtask

    task automatic complete();
        finish = 1'b1;
        rst_segundos = 1'b1;
        tick(1);
        finish = 1'b0;
        rst_segundos = 1'b0;
        exp_busy = 0;
        cur_t = '{0, 0, 0, 0, 0};
        chk("busy_done", int'(busy), 0);
        chk("sel_done", int'(sel), 0);
        chk_times("t_done");
    endtask

    initial begin
        int wait_n;
        int c;
        rst = 1'b0;
        btn = 3'd3;
        sin_azucar = 1'b0;
        rst_segundos = 1'b0;
        finish = 1'b0;

        // Reset held with a button pressed.
        tick(3);
        chk("rst_sel", int'(sel), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_seg", int'(segundos), 0);
        chk_times("rst_t");
        btn = 3'd0;
        rst = 1'b1;
        tick(1);
        chk("post_rst_busy", int'(busy), 0);
        chk("post_rst_sel", int'(sel), 0);

        // Free-running seconds, then a clear coinciding with a tick.
        tick(20);
        wait_n = 0;
        while ((m_cyc % TPS) != TPS - 1 && wait_n < 10) begin
            tick(1);
            wait_n++;
        end
        rst_segundos = 1'b1;
        tick(1);
        rst_segundos = 1'b0;
        chk("seg_clear_on_tick", int'(segundos), 0);

        // Cafe con leche, drops and completion.
        place_order(2, 1'b0);
        release_fsm();
        place_order(5, 1'b0);
        finish_alone();
        complete();
        place_order(1, 1'b0);
        release_fsm();
        complete();

        // No sugar.
        place_order(4, 1'b1);
        release_fsm();
        complete();

        // Invalid code.
        place_order(7, 1'b0);
        tick(4);
        chk("invalid_busy", int'(busy), 0);

        // Asynchronous reset while brewing.
        place_order(3, 1'b0);
        release_fsm();
        tick(2);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("async_busy", int'(busy), 0);
        chk("async_sel", int'(sel), 0);
        chk("async_seg", int'(segundos), 0);
        exp_busy = 0;
        cur_t = '{0, 0, 0, 0, 0};
        chk_times("async_t");
        tick(2);
        btn = 3'd0;
        rst = 1'b1;
        tick(1);

        // Randomized orders acting as the brewing FSM.
        for (int it = 0; it < 25; it++) begin
            c = $urandom_range(0, 7);
            place_order(c, 1'($urandom_range(0, 1)));
            if (exp_busy) begin
                tick($urandom_range(0, 4));
                chk("armed_hold_sel", int'(sel), c);
                release_fsm();
                tick($urandom_range(0, 6));
                if ($urandom_range(0, 1) == 1)
                    place_order($urandom_range(1, 5), 1'($urandom_range(0, 1)));
                if ($urandom_range(0, 1) == 1)
                    finish_alone();
                if ($urandom_range(0, 1) == 1) begin
                    rst_segundos = 1'b1;
                    tick(1);
                    rst_segundos = 1'b0;
                    tick($urandom_range(0, 9));
                end
                complete();
            end else begin
                tick(2);
            end
        end

        tick(2);
        chk("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
